// File: rtl/snake_pkg.sv
// Types and constants shared by the game core and the display scanner.
package snake_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_H = 16;

  // Playfield, indexed grid[y][x]; 1 = LED on.
  typedef logic [GRID_H-1:0][GRID_W-1:0] grid_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    HOLD
  } scan_state_t;

  localparam logic [3:0] LAST_ROW = 4'(GRID_H - 1);
  localparam logic [3:0] LAST_BIT = 4'(GRID_W - 1);

endpackage

// File: rtl/scan_tick_gen.sv
// Divider for the serial shift clock. It emits a one-cycle tick every
// CLK_DIV cycles while not cleared. The first tick after clear is released
// arrives CLK_DIV cycles later.
module scan_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic game_clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  // Down-counter reloaded on clear and on every terminal count.
  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (clear || (div_cnt == '0)) begin
      div_cnt <= RELOAD;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  assign tick = !clear && (div_cnt == '0);

endmodule

// File: rtl/grid_scan_driver.sv
// Row-multiplexed LED matrix scanner. It snapshots the playfield once per
// frame, shifts each row out MSB first (x=15 first), latches the row and
// holds it for ROW_HOLD cycles.
//
// state | meaning
// IDLE  | waiting for enable
// LOAD  | capture grid into snapshot, row counter = 0
// SHIFT | 16 bits of snapshot[row] on ser_data/ser_clk
// LATCH | ser_latch strobe, row_sel takes the row counter
// HOLD  | row displayed for ROW_HOLD cycles, then next row or frame end
module grid_scan_driver
  import snake_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int ROW_HOLD = 4
) (
  input  logic       game_clk,
  input  logic       reset_n,
  input  grid_t      grid,
  input  logic       enable,
  output logic       ser_data,
  output logic       ser_clk,
  output logic       ser_latch,
  output logic [3:0] row_sel,
  output logic       frame_done,
  output logic       busy
);

  localparam int            HW          = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(ROW_HOLD - 1);

  scan_state_t   state;
  scan_state_t   state_nxt;
  grid_t         snapshot;
  logic [3:0]    row_cnt;
  logic [3:0]    bit_cnt;
  logic          phase;
  logic [HW-1:0] hold_cnt;
  logic [3:0]    row_sel_q;

  logic div_clear;
  logic div_tick;
  logic shift_done;
  logic hold_done;
  logic last_row;

  assign div_clear = (state != SHIFT);

  scan_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .game_clk (game_clk),
    .reset_n  (reset_n),
    .clear    (div_clear),
    .tick     (div_tick)
  );

  // A bit ends on the tick that closes its high half; the row ends with x=0.
  assign shift_done = div_tick && phase && (bit_cnt == LAST_BIT);
  assign hold_done  = (hold_cnt == '0);
  assign last_row   = (row_cnt == LAST_ROW);

  // State register.
  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the outputs decoded from the current state.
  always_comb begin
    state_nxt  = state;
    ser_clk    = 1'b0;
    ser_data   = 1'b0;
    ser_latch  = 1'b0;
    frame_done = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (enable) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = SHIFT;
      end
      SHIFT: begin
        ser_clk  = phase;
        ser_data = snapshot[row_cnt][~bit_cnt];
        if (shift_done) state_nxt = LATCH;
      end
      LATCH: begin
        ser_latch = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (hold_done) begin
          if (!last_row) begin
            state_nxt = SHIFT;
          end else begin
            frame_done = 1'b1;
            state_nxt  = enable ? LOAD : IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame snapshot; later grid changes wait for the next LOAD.
  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) begin
      snapshot <= '0;
    end else if (state == LOAD) begin
      snapshot <= grid;
    end
  end

  // Row counter; it returns to 0 only through LOAD.
  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) begin
      row_cnt <= '0;
    end else if (state == LOAD) begin
      row_cnt <= '0;
    end else if ((state == HOLD) && hold_done && !last_row) begin
      row_cnt <= row_cnt + 1'b1;
    end
  end

  // Bit position and ser_clk phase; both restart whenever SHIFT is left.
  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      phase   <= 1'b0;
    end else if (state != SHIFT) begin
      bit_cnt <= '0;
      phase   <= 1'b0;
    end else if (div_tick) begin
      phase <= ~phase;
      if (phase) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Row dwell down-counter, armed during LATCH.
  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (state == LATCH) begin
      hold_cnt <= HOLD_RELOAD;
    end else if ((state == HOLD) && !hold_done) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // row_sel changes on the edge entering LATCH, together with the strobe.
  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) begin
      row_sel_q <= '0;
    end else if ((state == SHIFT) && shift_done) begin
      row_sel_q <= row_cnt;
    end
  end

  assign row_sel = row_sel_q;

endmodule

// File: doc/grid_scan_driver.md
Name: grid_scan_driver

Overview:
- Consumer end of the 16x16 `grid` bus that `snakegame` produces. It turns the parallel playfield into a row-multiplexed serial stream for the external LED matrix: a shift-register chain plus a row decoder.
- It snapshots the grid once per frame so there is no tearing. It then shifts out one 16-bit row at a time, latches it, drives the row select, and holds the row for a programmable dwell time.
- It sits between the game core and the board pins.

Parameters:
- CLK_DIV, 2: game_clk cycles per `ser_clk` half-period; must be >= 1.
- ROW_HOLD, 4: game_clk cycles each latched row is displayed before the next row starts shifting; must be >= 1.

Ports:
- game_clk  in  1  block clock; all logic is posedge.
- reset_n  in  1  asynchronous active-low reset.
- grid  in  16x16 (packed [15:0][15:0])  playfield, indexed grid[y][x]; 1 = LED on.
- enable  in  1  scanning allowed; sampled only in IDLE and at the frame boundary.
- ser_data  out  1  serial pixel data to the shift chain.
- ser_clk  out  1  shift clock; the chain samples on its rising edge.
- ser_latch  out  1  one-cycle strobe that transfers the shifted row to the column outputs.
- row_sel  out  4  currently displayed row y.
- frame_done  out  1  one-cycle pulse after row 15 hold completes.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - Go to IDLE; clear the snapshot, row counter, bit counter and divider.
  - Outputs: ser_data=0, ser_clk=0, ser_latch=0, row_sel=0, frame_done=0, busy=0.
- States: IDLE, LOAD, SHIFT, LATCH, HOLD (enum in package).
- IDLE: if enable=1 on a rising game_clk edge, next state is LOAD. Otherwise stay.
- LOAD (1 cycle):
  - Copy `grid` into the snapshot register and set row counter=0.
  - Next state is SHIFT.
- SHIFT:
  - Shift 16 bits of snapshot[row], MSB first (x=15 down to x=0).
  - Each bit takes 2*CLK_DIV cycles:
    - First CLK_DIV cycles: ser_clk=0, ser_data=bit.
    - Next CLK_DIV cycles: ser_clk=1, ser_data held.
  - ser_data changes only while ser_clk=0.
  - After bit x=0 completes (16*2*CLK_DIV cycles), next state is LATCH. ser_clk returns to 0.
- LATCH (1 cycle):
  - ser_latch=1 and row_sel <= row counter, both on the same edge.
  - Next state is HOLD.
- HOLD (ROW_HOLD cycles): ser_latch=0; row_sel stable.
  - At the end, if row<15: row+1, next state is SHIFT.
  - If row=15: frame_done=1 for one cycle. Next state is LOAD if enable=1, else IDLE.
  - The row counter wraps 15 -> 0 only via LOAD.
- Timing:
  - Row period = 32*CLK_DIV + 1 + ROW_HOLD cycles.
  - Frame period = 1 + 16*row period. With defaults: 69 cycles per row, 1105 per frame.
- Mid-frame `grid` changes are ignored until the next LOAD.
- enable deasserted mid-frame: the current frame completes, then the block goes to IDLE. row_sel keeps its last value (15).
- frame_done and the LOAD decision happen on the same cycle. The next snapshot is taken the cycle after the frame_done pulse.
- The divider is a down-counter reloaded to CLK_DIV-1. A toggle is issued when it reaches 0 and is active only in SHIFT.
- Reset mid-SHIFT: ser_clk drops to 0 immediately, with no latch pulse. The chain contents are don't-care until the next LATCH.

Decomposition:
- Shared package snake_pkg holds:
  - GRID_W=16, GRID_H=16.
  - typedef grid_t (logic [15:0][15:0]).
  - typedef scan_state_t (IDLE, LOAD, SHIFT, LATCH, HOLD).
- One sub-module, scan_tick_gen: a parameterised CLK_DIV divider with a clear input, emitting a one-cycle tick.
- The FSM, snapshot and counters live in grid_scan_driver.

Test Plan:
- Reset behaviour: assert reset_n=0 mid-SHIFT (CLK_DIV=2, ROW_HOLD=4) -> all outputs 0 in the same cycle; busy=0; after release with enable=0 the block stays in IDLE for 100 cycles.
- Single pixel: grid[0][15]=1, all others 0, enable=1 -> row 0 stream is 1 followed by fifteen 0s, sampled on ser_clk rises. The first ser_latch occurs 65 cycles after LOAD with row_sel=0. All other rows shift 16 zeros.
- Bit order / diagonal: grid[y][y]=1 for all y -> the row y stream has its single 1 at shift position 15-y; row_sel goes 0..15 in order.
- Frame timing: enable held at 1 -> frame_done pulses every 1105 cycles; exactly 16 ser_latch pulses between consecutive frame_done pulses; 16 ser_clk rises per latch.
- Tearing: flip the whole grid to all-ones during row 7 of a frame -> rows 8..15 of that frame still shift the old data; the next frame shifts all ones.
- Enable drop: deassert enable during row 3 -> rows 4..15 still complete, frame_done pulses once, busy falls the next cycle, and no further LOAD occurs.
